// File: rtl/fifo_drain_arbiter.sv
// Round-robin drain of N synchronous FIFOs onto one valid/ready stream.
// Each grant may repeat up to BURST times. Each read lands in the output register two cycles after issue.
module fifo_drain_arbiter #(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST      = 4,
    parameter int SRC_W      = $clog2(N)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N-1:0]            req_mask,
    input  logic [N-1:0]            fifo_empty,
    output logic [N-1:0]            fifo_rd_en,
    input  logic [N*DATA_WIDTH-1:0] fifo_rd_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic [SRC_W-1:0]        out_src,
    output logic                    busy
);
    localparam int CNT_W = $clog2(BURST + 1);

    typedef enum logic {ARB, LOCK} state_t;

    state_t             state;
    logic [SRC_W-1:0]   last;
    logic [SRC_W-1:0]   sel;
    logic [CNT_W-1:0]   burst_cnt;
    logic               inflight;

    logic [N-1:0]       elig;
    logic [SRC_W-1:0]   search_idx;
    logic [SRC_W-1:0]   grant_idx;
    logic               search_hit;
    logic               keep;
    logic               slot_free;
    logic               can_issue;
    int unsigned        k;

    always_comb begin
        elig       = req_mask & ~fifo_empty;
        search_idx = last;
        search_hit = 1'b0;
        k          = 0;
        // Scan last+1 .. last+N so that last itself is considered last.
        for (int unsigned i = 1; i <= N; i++) begin
            k = (32'(last) + i) % 32'(N);
            if (!search_hit && elig[k]) begin
                search_hit = 1'b1;
                search_idx = SRC_W'(k);
            end
        end
        keep       = (state == LOCK) && elig[last] && (burst_cnt < CNT_W'(BURST));
        grant_idx  = keep ? last : search_idx;
        slot_free  = ~inflight & (~out_valid | out_ready);
        // Gating with rst_n keeps the FIFOs untouched while held in reset.
        can_issue  = rst_n & slot_free & (|elig);
        fifo_rd_en = '0;
        if (can_issue) begin
            fifo_rd_en[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARB;
            last      <= SRC_W'(N - 1);
            burst_cnt <= '0;
            inflight  <= 1'b0;
            sel       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else begin
            if (inflight) begin
                out_valid <= 1'b1;
                out_data  <= fifo_rd_data[sel*DATA_WIDTH +: DATA_WIDTH];
                out_src   <= sel;
                inflight  <= 1'b0;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (can_issue) begin
                inflight <= 1'b1;
                sel      <= grant_idx;
                if (keep) begin
                    burst_cnt <= burst_cnt + CNT_W'(1);
                end else begin
                    last      <= search_idx;
                    burst_cnt <= CNT_W'(1);
                    state     <= LOCK;
                end
            end else if (slot_free && !(|elig)) begin
                state     <= ARB;
                burst_cnt <= '0;
            end
        end
    end

    assign busy = inflight | out_valid;

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// Bench for fifo_drain_arbiter: behavioural FIFO models, grant-rule reference model, per-source scoreboard.
module tb_fifo_drain_arbiter;
    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [N-1:0]    req_mask;
    logic [N-1:0]    fifo_empty;
    logic [N*DW-1:0] fifo_rd_data;
    logic            out_ready;

    logic [N-1:0]    rd_en_a, rd_en_b, rd_en;
    logic            ov_a, ov_b, ov;
    logic            busy_a, busy_b, busy;
    logic [DW-1:0]   od_a, od_b, od;
    logic [1:0]      os_a, os_b, os;
    logic            use_b1;

    fifo_drain_arbiter #(.N(N), .DATA_WIDTH(DW), .BURST(2), .SRC_W(2)) u_dut_b2 (
        .clk(clk), .rst_n(rst_n), .req_mask(req_mask), .fifo_empty(fifo_empty),
        .fifo_rd_en(rd_en_a), .fifo_rd_data(fifo_rd_data), .out_valid(ov_a),
        .out_ready(out_ready), .out_data(od_a), .out_src(os_a), .busy(busy_a));

    fifo_drain_arbiter #(.N(N), .DATA_WIDTH(DW), .BURST(1), .SRC_W(2)) u_dut_b1 (
        .clk(clk), .rst_n(rst_n), .req_mask(req_mask), .fifo_empty(fifo_empty),
        .fifo_rd_en(rd_en_b), .fifo_rd_data(fifo_rd_data), .out_valid(ov_b),
        .out_ready(out_ready), .out_data(od_b), .out_src(os_b), .busy(busy_b));

    assign rd_en = use_b1 ? rd_en_b : rd_en_a;
    assign ov    = use_b1 ? ov_b    : ov_a;
    assign busy  = use_b1 ? busy_b  : busy_a;
    assign od    = use_b1 ? od_b    : od_a;
    assign os    = use_b1 ? os_b    : os_a;

    // FIFO environment
    logic [DW-1:0] mem [N][DEPTH];
    int unsigned   wr_p [N];
    int unsigned   rd_p [N];
    int unsigned   dlv  [N];
    logic [DW-1:0] rd_reg [N];
    logic [N-1:0]  uflow;

    // Reference model state
    int unsigned   m_last, m_run, m_sel;
    logic          m_inflight, m_ov;
    logic [DW-1:0] m_od;
    logic [1:0]    m_os;

    int n_pass, n_total;
    int mdl_bad, sb_bad, n_dlv;
    logic [15:0] bad_obs, bad_exp;

    logic [N-1:0]  obs_rd_en, obs_empty;
    logic          obs_ov, obs_hs, obs_busy;
    logic [DW-1:0] obs_od;
    logic [1:0]    obs_os;

    task automatic refresh();
        for (int j = 0; j < N; j++) begin
            fifo_empty[j] = (wr_p[j] == rd_p[j]);
            fifo_rd_data[j*DW +: DW] = rd_reg[j];
        end
    endtask

    task automatic push(input int f, input logic [DW-1:0] d);
        mem[f][wr_p[f] % DEPTH] = d;
        wr_p[f]++;
        refresh();
    endtask

    task automatic flush();
        for (int j = 0; j < N; j++) begin
            rd_p[j] = wr_p[j];
            dlv[j]  = wr_p[j];
        end
        refresh();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        m_last = N - 1; m_run = 0; m_sel = 0;
        m_inflight = 1'b0; m_ov = 1'b0; m_od = '0; m_os = '0;
        for (int j = 0; j < N; j++) dlv[j] = rd_p[j];
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One clock: predict from the grant rules, sample the DUT, advance model and FIFOs.
    task automatic step();
        logic [N-1:0] el, exp_en;
        logic         free, found, rdy;
        int unsigned  g, lim;
        logic [15:0]  ov_v, ex_v;
        #1;
        lim    = use_b1 ? 1 : 2;
        el     = req_mask & ~fifo_empty;
        free   = !m_inflight && (!m_ov || out_ready);
        exp_en = '0;
        g      = m_last;
        found  = 1'b0;
        if (free && (|el)) begin
            if (m_run > 0 && m_run < lim && el[m_last]) begin
                g = m_last;
            end else begin
                for (int i = 1; i <= N; i++) begin
                    if (!found && el[(m_last + i) % N]) begin
                        g = (m_last + i) % N;
                        found = 1'b1;
                    end
                end
            end
            exp_en[g] = 1'b1;
        end
        rdy       = out_ready;
        obs_rd_en = rd_en; obs_ov = ov; obs_od = od; obs_os = os; obs_busy = busy;
        obs_hs    = ov && out_ready;
        obs_empty = fifo_empty;
        ov_v = {obs_rd_en, obs_ov, obs_od, obs_os, obs_busy};
        ex_v = {exp_en, m_ov, m_od, m_os, m_inflight | m_ov};
        if (ov_v !== ex_v) begin
            mdl_bad++;
            bad_obs = ov_v;
            bad_exp = ex_v;
        end
        @(posedge clk);
        #1;
        if (m_inflight) begin
            m_ov = 1'b1; m_od = rd_reg[m_sel]; m_os = 2'(m_sel); m_inflight = 1'b0;
        end else if (m_ov && rdy) begin
            m_ov = 1'b0;
        end
        if (exp_en != '0) begin
            m_inflight = 1'b1;
            m_sel = g;
            if (g == m_last && m_run > 0 && m_run < lim) m_run++;
            else begin m_last = g; m_run = 1; end
        end else if (free) begin
            m_run = 0;
        end
        for (int j = 0; j < N; j++) begin
            if (obs_rd_en[j]) begin
                if (wr_p[j] == rd_p[j]) uflow[j] = 1'b1;
                else begin
                    rd_reg[j] = mem[j][rd_p[j] % DEPTH];
                    rd_p[j]++;
                end
            end
        end
        if (obs_hs) begin
            if (obs_od !== mem[obs_os][dlv[obs_os] % DEPTH]) sb_bad++;
            dlv[obs_os]++;
            n_dlv++;
        end
        refresh();
    endtask

    task automatic test_reset();
        apply_reset();
        n_total++;
        if ({rd_en_a, ov_a, od_a, os_a, busy_a} !== 16'h0)
            $display("FAIL reset_b2: got %h expected 0000", {rd_en_a, ov_a, od_a, os_a, busy_a});
        else n_pass++;
        n_total++;
        if ({rd_en_b, ov_b, od_b, os_b, busy_b} !== 16'h0)
            $display("FAIL reset_b1: got %h expected 0000", {rd_en_b, ov_b, od_b, os_b, busy_b});
        else n_pass++;
        release_reset();
        step();
        n_total++;
        if ({obs_rd_en, obs_ov, obs_busy} !== 6'h0)
            $display("FAIL idle_after_reset: got %h expected 00", {obs_rd_en, obs_ov, obs_busy});
        else n_pass++;
    endtask

    task automatic test_single_source();
        logic [9:0]    re_hist, ov_hist;
        logic [23:0]   words;
        logic [5:0]    srcs;
        logic          busy7, other;
        int            nw, b0;
        apply_reset(); flush(); release_reset();
        out_ready = 1'b1; req_mask = '1;
        push(0, 8'h11); push(0, 8'h22); push(0, 8'h33);
        b0 = mdl_bad; nw = 0; words = 'x; srcs = 'x; busy7 = 1'bx; other = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            re_hist[i] = obs_rd_en[0];
            ov_hist[i] = obs_ov;
            if (obs_rd_en[3:1] != 3'b000) other = 1'b1;
            if (obs_hs && nw < 3) begin
                words[nw*8 +: 8] = obs_od;
                srcs[nw*2 +: 2]  = obs_os;
                nw++;
            end
            if (i == 7) busy7 = obs_busy;
        end
        n_total++;
        if ({other, re_hist} !== 11'b00000010101) $display("FAIL single_rd_en: got %b expected 00000010101", {other, re_hist});
        else n_pass++;
        n_total++;
        if (ov_hist !== 10'b0001010100) $display("FAIL single_valid: got %b expected 0001010100", ov_hist);
        else n_pass++;
        n_total++;
        if (words !== 24'h332211) $display("FAIL single_data: got %h expected 332211", words);
        else n_pass++;
        n_total++;
        if (srcs !== 6'b000000) $display("FAIL single_src: got %b expected 000000", srcs);
        else n_pass++;
        n_total++;
        if (busy7 !== 1'b0) $display("FAIL single_busy_T7: got %b expected 0", busy7);
        else n_pass++;
        n_total++;
        if (mdl_bad !== b0) $display("FAIL single_model: got %h expected %h", bad_obs, bad_exp);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [19:0] got, want;
        int          ns, b0, s0;
        int          order [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
        apply_reset(); flush(); release_reset();
        out_ready = 1'b1; req_mask = '1;
        for (int f = 0; f < N; f++)
            for (int w = 0; w < 8; w++) push(f, 8'($urandom));
        b0 = mdl_bad; s0 = sb_bad; ns = 0; got = 'x;
        for (int i = 0; i < 10; i++) want[i*2 +: 2] = 2'(order[i]);
        for (int i = 0; i < 40 && ns < 10; i++) begin
            step();
            if (obs_hs) begin
                got[ns*2 +: 2] = obs_os;
                ns++;
            end
        end
        n_total++;
        if (got !== want) $display("FAIL rr_src_order: got %h expected %h", got, want);
        else n_pass++;
        n_total++;
        if (sb_bad !== s0) $display("FAIL rr_data_order: got %0d bad words expected 0", sb_bad - s0);
        else n_pass++;
        n_total++;
        if (mdl_bad !== b0) $display("FAIL rr_model: got %h expected %h", bad_obs, bad_exp);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] held;
        logic          seen, stable, quiet, h1, h2, hs_ok;
        int            b0, s0, d0;
        apply_reset(); flush(); release_reset();
        req_mask = '1; out_ready = 1'b0;
        for (int w = 0; w < 3; w++) begin
            push(1, 8'h40 + 8'(w));
            push(2, 8'h80 + 8'(w));
        end
        b0 = mdl_bad; s0 = sb_bad; d0 = n_dlv; seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            step();
            if (obs_ov) seen = 1'b1;
        end
        n_total++;
        if (seen !== 1'b1) $display("FAIL bp_first_valid_timeout: got %b expected 1", seen);
        else n_pass++;
        held = obs_od; stable = 1'b1; quiet = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (obs_od !== held || obs_ov !== 1'b1) stable = 1'b0;
            if (obs_rd_en !== '0) quiet = 1'b0;
        end
        n_total++;
        if (stable !== 1'b1) $display("FAIL bp_hold_stable: got %h expected %h", obs_od, held);
        else n_pass++;
        n_total++;
        if (quiet !== 1'b1) $display("FAIL bp_no_issue: got %b expected 0000", obs_rd_en);
        else n_pass++;
        out_ready = 1'b1;
        step();
        hs_ok = obs_hs && (obs_rd_en != '0);
        step(); h1 = obs_ov;
        step(); h2 = obs_ov;
        n_total++;
        if ({hs_ok, h1, h2} !== 3'b101) $display("FAIL bp_resume: got %b expected 101", {hs_ok, h1, h2});
        else n_pass++;
        for (int i = 0; i < 30; i++) step();
        n_total++;
        if (n_dlv - d0 !== 6) $display("FAIL bp_word_count: got %0d expected 6", n_dlv - d0);
        else n_pass++;
        n_total++;
        if (sb_bad !== s0 || mdl_bad !== b0) $display("FAIL bp_model: got %h expected %h", bad_obs, bad_exp);
        else n_pass++;
    endtask

    task automatic test_mask();
        logic [7:0]  first4;
        logic [15:0] later;
        logic        viol, stray;
        int          ns, b0, s0;
        use_b1 = 1'b1;
        apply_reset(); flush(); release_reset();
        out_ready = 1'b1; req_mask = 4'b1010;
        for (int w = 0; w < 16; w++) push(1, 8'($urandom));
        for (int w = 0; w < 3; w++)  push(3, 8'($urandom));
        for (int w = 0; w < 4; w++) begin
            push(0, 8'($urandom));
            push(2, 8'($urandom));
        end
        b0 = mdl_bad; s0 = sb_bad; ns = 0; first4 = 'x; later = 'x; viol = 1'b0; stray = 1'b0;
        for (int i = 0; i < 40 && ns < 12; i++) begin
            step();
            if (obs_rd_en[3] && obs_empty[3]) viol = 1'b1;
            if (obs_rd_en[0] || obs_rd_en[2]) stray = 1'b1;
            if (obs_hs) begin
                if (ns < 4) first4[ns*2 +: 2] = obs_os;
                else if (ns >= 6) later[(ns-6)*2 +: 2] = obs_os;
                ns++;
            end
        end
        n_total++;
        if (first4 !== 8'b11_01_11_01) $display("FAIL mask_alternate: got %b expected 11011101", first4);
        else n_pass++;
        n_total++;
        if (later[11:0] !== 12'b01_01_01_01_01_01) $display("FAIL mask_after_empty: got %b expected 010101010101", later[11:0]);
        else n_pass++;
        n_total++;
        if ({viol, stray} !== 2'b00) $display("FAIL mask_illegal_read: got %b expected 00", {viol, stray});
        else n_pass++;
        n_total++;
        if (sb_bad !== s0 || mdl_bad !== b0) $display("FAIL mask_model: got %h expected %h", bad_obs, bad_exp);
        else n_pass++;
        use_b1 = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [1:0] pre;
        int         b0, s0;
        apply_reset(); flush(); release_reset();
        req_mask = '1; out_ready = 1'b0;
        for (int w = 0; w < 4; w++) push(2, 8'hA0 + 8'(w));
        for (int i = 0; i < 3; i++) step();
        pre = {ov, busy};
        n_total++;
        if (pre !== 2'b11) $display("FAIL mid_pre_busy: got %b expected 11", pre);
        else n_pass++;
        for (int w = 0; w < 4; w++) push(1, 8'h50 + 8'(w));
        apply_reset();
        n_total++;
        if ({rd_en, ov, od, os, busy} !== 16'h0)
            $display("FAIL mid_async_clear: got %h expected 0000", {rd_en, ov, od, os, busy});
        else n_pass++;
        release_reset();
        out_ready = 1'b1;
        b0 = mdl_bad; s0 = sb_bad;
        step();
        n_total++;
        if (obs_rd_en !== 4'b0010) $display("FAIL mid_first_grant: got %b expected 0010", obs_rd_en);
        else n_pass++;
        for (int i = 0; i < 20; i++) step();
        n_total++;
        if (sb_bad !== s0 || mdl_bad !== b0) $display("FAIL mid_model: got %h expected %h", bad_obs, bad_exp);
        else n_pass++;
    endtask

    task automatic test_random();
        int b0, s0, d0, left;
        apply_reset(); flush(); release_reset();
        req_mask = '1; out_ready = 1'b1;
        b0 = mdl_bad; s0 = sb_bad; d0 = n_dlv;
        for (int c = 0; c < 2000; c++) begin
            for (int f = 0; f < N; f++)
                if ($urandom_range(0, 11) == 0 && (wr_p[f] - dlv[f]) < 200) push(f, 8'($urandom));
            if ($urandom_range(0, 15) == 0) req_mask = 4'($urandom) | 4'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        req_mask = '1; out_ready = 1'b1;
        left = 1;
        for (int i = 0; i < 3000 && left != 0; i++) begin
            step();
            left = 0;
            for (int f = 0; f < N; f++) left += int'(wr_p[f] - dlv[f]);
        end
        n_total++;
        if (left !== 0) $display("FAIL rand_drain_timeout: got %0d words left expected 0", left);
        else n_pass++;
        n_total++;
        if (n_dlv - d0 <= 200) $display("FAIL rand_throughput: got %0d words expected >200", n_dlv - d0);
        else n_pass++;
        n_total++;
        if (sb_bad !== s0) $display("FAIL rand_scoreboard: got %0d bad words expected 0", sb_bad - s0);
        else n_pass++;
        n_total++;
        if (mdl_bad !== b0) $display("FAIL rand_model: got %h expected %h", bad_obs, bad_exp);
        else n_pass++;
        n_total++;
        if (uflow !== '0) $display("FAIL underflow: got %b expected 0000", uflow);
        else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0; out_ready = 1'b1; req_mask = '1; use_b1 = 1'b0; uflow = '0;
        n_pass = 0; n_total = 0; mdl_bad = 0; sb_bad = 0; n_dlv = 0;
        bad_obs = '0; bad_exp = '0;
        for (int j = 0; j < N; j++) begin
            wr_p[j] = 0; rd_p[j] = 0; dlv[j] = 0; rd_reg[j] = '0;
        end
        refresh();
        test_reset();
        test_single_source();
        test_round_robin();
        test_backpressure();
        test_mask();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
